// File: rtl/load_ext_pipe.sv
// Two-stage load-data / immediate extender: stage A aligns by byte offset, stage B extends.
// Define LOAD_EXT_HIMM_EN to turn mode 11 into a high-immediate (generalised lui); otherwise it is reserved.
module load_ext_pipe #(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [1:0]        in_mode,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  typedef enum logic [1:0] {M_BYTE = 2'b00, M_HALF = 2'b01, M_WORD = 2'b10, M_HIMM = 2'b11} mode_e;

  logic              a_v_q, a_v_d;
  logic [DATA_W-1:0] a_shift_q, a_shift_d;
  mode_e             a_mode_q, a_mode_d;
  logic              a_sign_q, a_sign_d;
  logic              a_err_q, a_err_d;
  logic              b_v_q, b_v_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              b_err_q, b_err_d;

  logic              a_adv;
  logic              accept;
  logic [DATA_W-1:0] shifted;
  logic              err_in;
  logic [DATA_W-1:0] ext;

  assign a_adv    = !b_v_q || out_ready;
  assign in_ready = !reset && !flush && (!a_v_q || a_adv);
  assign accept   = in_valid && in_ready;
  assign shifted  = in_data >> {in_off, 3'b000};

  always_comb begin
    err_in = 1'b0;
    case (mode_e'(in_mode))
      M_BYTE:  err_in = 1'b0;
      M_HALF:  err_in = in_off[0];
      M_WORD:  err_in = (in_off != '0);
`ifdef LOAD_EXT_HIMM_EN
      M_HIMM:  err_in = 1'b0;
`else
      M_HIMM:  err_in = 1'b1;
`endif
      default: err_in = 1'b1;
    endcase
  end

  always_comb begin
    ext = '0;
    case (a_mode_q)
      M_BYTE:  ext = {{(DATA_W-8){a_sign_q & a_shift_q[7]}}, a_shift_q[7:0]};
      M_HALF:  ext = {{(DATA_W-16){a_sign_q & a_shift_q[15]}}, a_shift_q[15:0]};
      M_WORD:  ext = a_shift_q;
`ifdef LOAD_EXT_HIMM_EN
      M_HIMM:  ext = {a_shift_q[15:0], {(DATA_W-16){1'b0}}};
`else
      M_HIMM:  ext = '0;
`endif
      default: ext = '0;
    endcase
    if (a_err_q) ext = '0;
  end

  always_comb begin
    a_v_d     = a_v_q;
    a_shift_d = a_shift_q;
    a_mode_d  = a_mode_q;
    a_sign_d  = a_sign_q;
    a_err_d   = a_err_q;
    b_v_d     = b_v_q;
    b_data_d  = b_data_q;
    b_err_d   = b_err_q;
    if (flush) begin
      a_v_d = 1'b0;
      b_v_d = 1'b0;
    end else begin
      if (a_adv) begin
        b_v_d = a_v_q;
        if (a_v_q) begin
          b_data_d = ext;
          b_err_d  = a_err_q;
        end
      end
      if (accept) begin
        a_v_d     = 1'b1;
`ifdef LOAD_EXT_HIMM_EN
        // High-immediate takes the unshifted low half, so keep the raw word.
        a_shift_d = (mode_e'(in_mode) == M_HIMM) ? in_data : shifted;
`else
        a_shift_d = shifted;
`endif
        a_mode_d  = mode_e'(in_mode);
        a_sign_d  = in_sign;
        a_err_d   = err_in;
      end else if (a_adv) begin
        a_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_v_q     <= 1'b0;
      a_shift_q <= '0;
      a_mode_q  <= M_BYTE;
      a_sign_q  <= 1'b0;
      a_err_q   <= 1'b0;
      b_v_q     <= 1'b0;
      b_data_q  <= '0;
      b_err_q   <= 1'b0;
    end else begin
      a_v_q     <= a_v_d;
      a_shift_q <= a_shift_d;
      a_mode_q  <= a_mode_d;
      a_sign_q  <= a_sign_d;
      a_err_q   <= a_err_d;
      b_v_q     <= b_v_d;
      b_data_q  <= b_data_d;
      b_err_q   <= b_err_d;
    end
  end

  assign out_valid = b_v_q;
  assign out_data  = b_data_q;
  assign out_err   = b_err_q;

endmodule

// File: tb/tb_load_ext_pipe.sv
// Directed bench for load_ext_pipe: vector table plus streaming, flush, reset and 64-bit corner sequences.
module tb_load_ext_pipe;

`ifdef LOAD_EXT_HIMM_EN
  localparam bit HIMM = 1'b1;
`else
  localparam bit HIMM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_sign, out_valid, out_ready, out_err;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_off, in_mode;

  logic        f64, v64, r64, s64, ov64, or64, oe64;
  logic [63:0] d64, od64;
  logic [2:0]  off64;
  logic [1:0]  m64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_ext_pipe #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_off(in_off), .in_mode(in_mode), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err));

  load_ext_pipe #(.DATA_W(64)) dut64 (
    .clk(clk), .reset(reset), .flush(f64), .in_valid(v64), .in_ready(r64),
    .in_data(d64), .in_off(off64), .in_mode(m64), .in_sign(s64),
    .out_valid(ov64), .out_ready(or64), .out_data(od64), .out_err(oe64));

  typedef struct {
    string       name;
    logic [31:0] d;
    logic [1:0]  off;
    logic [1:0]  mode;
    logic        sign;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send32(input vec_t v);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = v.d; in_off = v.off; in_mode = v.mode; in_sign = v.sign;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({v.name, "_lat"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk({v.name, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({v.name, "_data"}, {32'd0, out_data}, {32'd0, v.ed});
    chk({v.name, "_err"}, {63'd0, out_err}, {63'd0, v.ee});
  endtask

  task automatic send64(input string name, input logic [63:0] d, input logic [2:0] off,
                        input logic [1:0] mode, input logic sign,
                        input logic [63:0] ed, input logic ee);
    @(posedge clk); #1;
    v64 = 1'b1; d64 = d; off64 = off; m64 = mode; s64 = sign;
    @(posedge clk); #1;
    v64 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({name, "_valid"}, {63'd0, ov64}, 64'd1);
    chk({name, "_data"}, od64, ed);
    chk({name, "_err"}, {63'd0, oe64}, {63'd0, ee});
  endtask

  initial begin
    int sent, rx, cyc;
    bit seen;

    vt[0]  = '{"b_off1_s",  32'h12F480AB, 2'd1, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0};
    vt[1]  = '{"b_off1_z",  32'h12F480AB, 2'd1, 2'b00, 1'b0, 32'h00000080, 1'b0};
    vt[2]  = '{"h_off2_s",  32'h80017FFF, 2'd2, 2'b01, 1'b1, 32'hFFFF8001, 1'b0};
    vt[3]  = '{"h_off1_err",32'h80017FFF, 2'd1, 2'b01, 1'b1, 32'h00000000, 1'b1};
    vt[4]  = '{"h_off0_s",  32'h80017FFF, 2'd0, 2'b01, 1'b1, 32'h00007FFF, 1'b0};
    vt[5]  = '{"h_off2_z",  32'h80017FFF, 2'd2, 2'b01, 1'b0, 32'h00008001, 1'b0};
    vt[6]  = '{"w_off0",    32'hDEADBEEF, 2'd0, 2'b10, 1'b1, 32'hDEADBEEF, 1'b0};
    vt[7]  = '{"w_off2_err",32'hDEADBEEF, 2'd2, 2'b10, 1'b0, 32'h00000000, 1'b1};
    vt[8]  = '{"b_off3_s",  32'h12F480AB, 2'd3, 2'b00, 1'b1, 32'h00000012, 1'b0};
    vt[9]  = '{"b_off2_s",  32'h12F480AB, 2'd2, 2'b00, 1'b1, 32'hFFFFFFF4, 1'b0};
    vt[10] = '{"h_off3_err",32'h12F480AB, 2'd3, 2'b01, 1'b0, 32'h00000000, 1'b1};
    vt[11] = '{"m11",       32'h1234BEEF, 2'd2, 2'b11, 1'b1,
               HIMM ? 32'hBEEF0000 : 32'h00000000, !HIMM};
    vt[12] = '{"b_off0_s",  32'h000000AB, 2'd0, 2'b00, 1'b1, 32'hFFFFFFAB, 1'b0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_off = '0;
    in_mode = '0; in_sign = 1'b0; out_ready = 1'b1;
    f64 = 1'b0; v64 = 1'b0; d64 = '0; off64 = '0; m64 = '0; s64 = 1'b0; or64 = 1'b1;

    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("post_rst_out_data", {32'd0, out_data}, 64'd0);

    foreach (vt[i]) send32(vt[i]);

    // Streaming: 8 words, out_ready pattern 1,0,0,1 repeating.
    sent = 0; rx = 0; cyc = 0;
    while (rx < 8 && cyc < 200) begin
      @(posedge clk); #1;
      in_valid  = (sent < 8);
      in_data   = 32'hA5000000 | sent;
      in_off    = 2'd0;
      in_mode   = 2'b10;
      in_sign   = 1'b0;
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      @(negedge clk);
      chk("stream_in_ready", {63'd0, in_ready}, {63'd0, !((sent - rx) == 2 && !out_ready)});
      if (out_valid && out_ready) begin
        chk("stream_data", {32'd0, out_data}, {32'd0, 32'hA5000000 | rx});
        chk("stream_err", {63'd0, out_err}, 64'd0);
        rx++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("stream_count", 64'(rx), 64'd8);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("stream_no_dup", {63'd0, seen}, 64'd0);

    // Flush with two in flight and a third offered during the flush cycle.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b10; in_off = 2'd0; in_data = 32'h11111111;
    @(posedge clk); #1;
    in_data = 32'h22222222;
    @(posedge clk); #1;
    in_data = 32'h33333333; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_output", {63'd0, seen}, 64'd0);

    // Reset with both stages full.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b10; in_data = 32'h5A5A5A5A;
    @(posedge clk); #1;
    in_data = 32'h6B6B6B6B;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_out_valid", {63'd0, out_valid}, 64'd1);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_data", {32'd0, out_data}, 64'd0);
    chk("midrst_out_err", {63'd0, out_err}, 64'd0);
    chk("midrst_in_ready_after", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;

    // 64-bit instance.
    send64("w64_m11", 64'h0123456789ABBEEF, 3'd3, 2'b11, 1'b1,
           HIMM ? 64'hBEEF000000000000 : 64'd0, !HIMM);
    send64("w64_b_off7", 64'h80FFFFFFFFFFFF00, 3'd7, 2'b00, 1'b1, 64'hFFFFFFFFFFFFFF80, 1'b0);
    send64("w64_h_off6", 64'h8001000000000000, 3'd6, 2'b01, 1'b0, 64'h0000000000008001, 1'b0);
    send64("w64_w_off4", 64'h0123456789ABCDEF, 3'd4, 2'b10, 1'b0, 64'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
